// File: rtl/tomasulo_pkg.sv
// Shared definitions for the tomasulo core and its host-side program loader:
// opcode encodings, execution latencies, instruction field offsets, loader states.
package tomasulo_pkg;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b101;

  localparam int LAT_LOAD = 2;
  localparam int LAT_ADD  = 1;
  localparam int LAT_SUB  = 1;
  localparam int LAT_MUL  = 4;
  localparam int LAT_DIV  = 8;

  // Instruction word layout: [11:9] opcode, [8:6] dst, [5:3] src1, [2:0] src2
  localparam int OPC_LSB  = 9;
  localparam int DST_LSB  = 6;
  localparam int SRC1_LSB = 3;
  localparam int SRC2_LSB = 0;
  localparam int FIELD_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CORE_RST = 3'd1,
    ST_STREAM   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } loader_state_t;

endpackage

// File: rtl/tomasulo_prog_mem.sv
// Host-written program store: one synchronous write port, one combinational
// read port; the loader registers the read data before it reaches the core.
module tomasulo_prog_mem #(
  parameter int DEPTH = 31,
  parameter int WIDTH = 12,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; the program survives a loader reset and
  // clearing it would only cost a wide reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = ({1'b0, i_rd_addr} < LP_DEPTH) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/tomasulo_program_loader.sv
// Host-side transmitter of the instruction / load_instruction / loading_complete
// protocol: resets the core, streams the stored program, then times the run.
module tomasulo_program_loader
  import tomasulo_pkg::*;
#(
  parameter int NUM_INSTRUCTIONS  = 31,
  parameter int INSTR_WIDTH       = 12,
  parameter int NUM_CYCLES        = 500,
  parameter int CYCLE_WIDTH       = $clog2(NUM_CYCLES),
  parameter int INSTRUCTION_WIDTH = $clog2(NUM_INSTRUCTIONS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prog_wr_en,
  input  logic [INSTRUCTION_WIDTH-1:0] prog_wr_addr,
  input  logic [INSTR_WIDTH-1:0]       prog_wr_data,
  input  logic [INSTRUCTION_WIDTH:0]   prog_len,
  input  logic                         start,
  input  logic [NUM_INSTRUCTIONS-1:0]  commit_in,
  output logic                         core_reset,
  output logic [INSTR_WIDTH-1:0]       instruction,
  output logic                         load_instruction,
  output logic                         loading_complete,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CYCLE_WIDTH-1:0]       cycle_count
);

  localparam logic [INSTRUCTION_WIDTH:0] LP_MAX_LEN = (INSTRUCTION_WIDTH+1)'(NUM_INSTRUCTIONS);
  localparam logic [CYCLE_WIDTH-1:0]     LP_LAST_CYCLE = CYCLE_WIDTH'(NUM_CYCLES - 1);

  loader_state_t                 r_state;
  logic [INSTRUCTION_WIDTH:0]    r_len;
  logic [INSTRUCTION_WIDTH:0]    r_ptr;
  logic                          r_core_reset;
  logic [INSTR_WIDTH-1:0]        r_instruction;
  logic                          r_load_instruction;
  logic                          r_loading_complete;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_timeout;
  logic [CYCLE_WIDTH-1:0]        r_cycle_count;

  logic                          w_wr_en;
  logic [INSTR_WIDTH-1:0]        w_rd_data;
  logic [NUM_INSTRUCTIONS-1:0]   w_mask;
  logic                          w_all_commit;
  logic                          w_start_ok;

  // Host may only rewrite the program while nothing is being streamed or run.
  assign w_wr_en = prog_wr_en
                && ((r_state == ST_IDLE) || (r_state == ST_DONE))
                && ({1'b0, prog_wr_addr} < LP_MAX_LEN);

  assign w_mask       = ~({NUM_INSTRUCTIONS{1'b1}} << r_len);
  assign w_all_commit = ((commit_in & w_mask) == w_mask);
  assign w_start_ok   = start && (prog_len != '0);

  tomasulo_prog_mem #(
    .DEPTH (NUM_INSTRUCTIONS),
    .WIDTH (INSTR_WIDTH),
    .AW    (INSTRUCTION_WIDTH)
  ) u_prog_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (prog_wr_addr),
    .i_wr_data (prog_wr_data),
    .i_rd_addr (r_ptr[INSTRUCTION_WIDTH-1:0]),
    .o_rd_data (w_rd_data)
  );

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values; a blocking write would leak into later decisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state            <= ST_IDLE;
      r_len              <= '0;
      r_ptr              <= '0;
      r_core_reset       <= 1'b0;
      r_instruction      <= '0;
      r_load_instruction <= 1'b0;
      r_loading_complete <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_timeout          <= 1'b0;
      r_cycle_count      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_len              <= (prog_len > LP_MAX_LEN) ? LP_MAX_LEN : prog_len;
            r_ptr              <= '0;
            r_cycle_count      <= '0;
            r_done             <= 1'b0;
            r_timeout          <= 1'b0;
            r_loading_complete <= 1'b0;
            r_core_reset       <= 1'b1;
            r_busy             <= 1'b1;
            r_state            <= ST_CORE_RST;
          end
        end

        ST_CORE_RST: begin
          // len is never zero here, so word 0 always goes out next cycle.
          r_core_reset       <= 1'b0;
          r_load_instruction <= 1'b1;
          r_instruction      <= w_rd_data;
          r_ptr              <= r_ptr + 1'b1;
          r_state            <= ST_STREAM;
        end

        ST_STREAM: begin
          if (r_ptr == r_len) begin
            r_load_instruction <= 1'b0;
            r_instruction      <= '0;
            r_loading_complete <= 1'b1;
            r_cycle_count      <= '0;
            r_state            <= ST_RUN;
          end else begin
            r_instruction <= w_rd_data;
            r_ptr         <= r_ptr + 1'b1;
          end
        end

        ST_RUN: begin
          // Commit is tested first so a coincident budget expiry reports a pass.
          if (w_all_commit) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_DONE;
          end else if (r_cycle_count == LP_LAST_CYCLE) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_reset       = r_core_reset;
  assign instruction      = r_instruction;
  assign load_instruction = r_load_instruction;
  assign loading_complete = r_loading_complete;
  assign busy             = r_busy;
  assign done             = r_done;
  assign timeout          = r_timeout;
  assign cycle_count      = r_cycle_count;

endmodule
